// File: rtl/flash_cmd_sequencer.sv
// Parallel NOR flash command sequencer: issues unlock/command write cycles for
// program, sector erase, chip erase and read-array reset, then polls DQ6/DQ5.
module flash_cmd_sequencer #(
  parameter int unsigned WE_PULSE = 2,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [26:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [26:0] flash_addr,
  output logic [7:0]  flash_dq_out,
  output logic        flash_dq_oe,
  input  logic [7:0]  flash_dq_in,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n
);

  localparam logic [26:0] U1      = 27'h0000AAA;
  localparam logic [26:0] U2      = 27'h0000555;
  localparam logic [3:0]  WE_LOAD = 4'(WE_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WE    = 3'd2,
    HOLD  = 3'd3,
    RD1   = 3'd4,
    RD2   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  // Index of the final write of each command sequence.
  function automatic logic [2:0] last_idx(input logic [1:0] o);
    case (o)
      2'b00:   last_idx = 3'd3;
      2'b01:   last_idx = 3'd5;
      2'b10:   last_idx = 3'd5;
      default: last_idx = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] cmd_data(input logic [1:0] o, input logic [2:0] idx,
                                          input logic [7:0] wd);
    if (o == 2'b11) begin
      cmd_data = 8'hF0;
    end else begin
      case (idx)
        3'd0:    cmd_data = 8'hAA;
        3'd1:    cmd_data = 8'h55;
        3'd2:    cmd_data = (o == 2'b00) ? 8'hA0 : 8'h80;
        3'd3:    cmd_data = (o == 2'b00) ? wd : 8'hAA;
        3'd4:    cmd_data = 8'h55;
        default: cmd_data = (o == 2'b01) ? 8'h30 : 8'h10;
      endcase
    end
  endfunction

  function automatic logic [26:0] cmd_addr(input logic [1:0] o, input logic [2:0] idx,
                                           input logic [26:0] a);
    if (o == 2'b11) begin
      cmd_addr = a;
    end else begin
      case (idx)
        3'd0:    cmd_addr = U1;
        3'd1:    cmd_addr = U2;
        3'd2:    cmd_addr = U1;
        3'd3:    cmd_addr = (o == 2'b00) ? a : U1;
        3'd4:    cmd_addr = U2;
        default: cmd_addr = (o == 2'b01) ? a : U1;
      endcase
    end
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  wr_idx_r, wr_idx_s;
  logic [3:0]  we_cnt_r, we_cnt_s;
  logic        rd_ph_r, rd_ph_s;
  logic [15:0] poll_cnt_r, poll_cnt_s;
  logic        dq6_r, dq6_s;
  logic [1:0]  op_r, op_s;
  logic [26:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        error_r, error_s;
  logic        busy_r, busy_s, done_r, done_s;
  logic        ce_n_r, ce_n_s, oe_n_r, oe_n_s, we_n_r, we_n_s, dq_oe_r, dq_oe_s;
  logic [26:0] faddr_r, faddr_s;
  logic [7:0]  dq_out_r, dq_out_s;
  logic        unused_dq_s;

  // Only DQ6 (toggle) and DQ5 (failure) carry status during polling.
  assign unused_dq_s = ^{flash_dq_in[7], flash_dq_in[4:0]};

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_s    = state_r;
    wr_idx_s   = wr_idx_r;
    we_cnt_s   = we_cnt_r;
    rd_ph_s    = rd_ph_r;
    poll_cnt_s = poll_cnt_r;
    dq6_s      = dq6_r;
    op_s       = op_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    error_s    = error_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s    = SETUP;
          op_s       = op;
          addr_s     = addr;
          wdata_s    = wdata;
          wr_idx_s   = 3'd0;
          poll_cnt_s = 16'd0;
          error_s    = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s  = WE;
        we_cnt_s = WE_LOAD;
      end
      WE: begin
        if (we_cnt_r == 4'd0) begin
          state_s = HOLD;
        end else begin
          we_cnt_s = we_cnt_r - 4'd1;
        end
      end
      HOLD: begin
        if (wr_idx_r != last_idx(op_r)) begin
          wr_idx_s = wr_idx_r + 3'd1;
          state_s  = SETUP;
        end else if (op_r == 2'b11) begin
          state_s = DONE;
        end else begin
          state_s = RD1;
          rd_ph_s = 1'b0;
        end
      end
      RD1: begin
        if (!rd_ph_r) begin
          rd_ph_s = 1'b1;
        end else begin
          dq6_s   = flash_dq_in[6];
          rd_ph_s = 1'b0;
          state_s = RD2;
        end
      end
      RD2: begin
        if (!rd_ph_r) begin
          rd_ph_s = 1'b1;
        end else begin
          rd_ph_s = 1'b0;
          // Stable DQ6 means the embedded algorithm finished; timeout beats another poll.
          if (dq6_r == flash_dq_in[6]) begin
            state_s = DONE;
          end else if (flash_dq_in[5]) begin
            state_s = ERR;
            error_s = 1'b1;
          end else if (({1'b0, poll_cnt_r} + 17'd1) >= {1'b0, TIMEOUT}) begin
            state_s = ERR;
            error_s = 1'b1;
          end else begin
            poll_cnt_s = poll_cnt_r + 16'd1;
            state_s    = RD1;
          end
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Bus and status values for the upcoming cycle, registered below.
  always_comb begin
    busy_s   = 1'b0;
    done_s   = (state_s == DONE);
    ce_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    we_n_s   = 1'b1;
    dq_oe_s  = 1'b0;
    faddr_s  = 27'd0;
    dq_out_s = 8'd0;
    case (state_s)
      SETUP, WE, HOLD: begin
        busy_s   = 1'b1;
        ce_n_s   = 1'b0;
        we_n_s   = (state_s == WE) ? 1'b0 : 1'b1;
        dq_oe_s  = 1'b1;
        faddr_s  = cmd_addr(op_s, wr_idx_s, addr_s);
        dq_out_s = cmd_data(op_s, wr_idx_s, wdata_s);
      end
      RD1, RD2: begin
        busy_s  = 1'b1;
        ce_n_s  = 1'b0;
        oe_n_s  = 1'b0;
        faddr_s = cmd_addr(op_s, wr_idx_s, addr_s);
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wr_idx_r   <= 3'd0;
      we_cnt_r   <= 4'd0;
      rd_ph_r    <= 1'b0;
      poll_cnt_r <= 16'd0;
      dq6_r      <= 1'b0;
      op_r       <= 2'd0;
      addr_r     <= 27'd0;
      wdata_r    <= 8'd0;
      error_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ce_n_r     <= 1'b1;
      oe_n_r     <= 1'b1;
      we_n_r     <= 1'b1;
      dq_oe_r    <= 1'b0;
      faddr_r    <= 27'd0;
      dq_out_r   <= 8'd0;
    end else begin
      state_r    <= state_s;
      wr_idx_r   <= wr_idx_s;
      we_cnt_r   <= we_cnt_s;
      rd_ph_r    <= rd_ph_s;
      poll_cnt_r <= poll_cnt_s;
      dq6_r      <= dq6_s;
      op_r       <= op_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      error_r    <= error_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ce_n_r     <= ce_n_s;
      oe_n_r     <= oe_n_s;
      we_n_r     <= we_n_s;
      dq_oe_r    <= dq_oe_s;
      faddr_r    <= faddr_s;
      dq_out_r   <= dq_out_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign flash_ce_n   = ce_n_r;
  assign flash_oe_n   = oe_n_r;
  assign flash_we_n   = we_n_r;
  assign flash_dq_oe  = dq_oe_r;
  assign flash_addr   = faddr_r;
  assign flash_dq_out = dq_out_r;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Scoreboard bench for flash_cmd_sequencer: expected bus writes are queued at
// request time and popped as the DUT performs them; a small flash model answers polls.
module tb_flash_cmd_sequencer;

  typedef struct packed {
    logic [26:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        m2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [26:0] addr = 27'd0;
  logic [7:0]  wdata = 8'd0;
  logic        busy, done, error, flash_dq_oe, flash_ce_n, flash_oe_n, flash_we_n;
  logic [26:0] flash_addr;
  logic [7:0]  flash_dq_out;
  logic [7:0]  flash_dq_in = 8'd0;

  logic        t_req = 1'b0;
  logic        t_busy, t_done, t_error, t_dq_oe, t_ce_n, t_oe_n, t_we_n;
  logic [26:0] t_faddr;
  logic [7:0]  t_dq_out;
  logic [7:0]  t_dq_in = 8'd0;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  int cyc = 0, done_cnt = 0, err_cnt = 0, poll_cyc = 0, wr_seen = 0;
  int t_busy_at = 0, t_done_at = 0, t_err_at = 0, t_rd_at = 0;
  int toggle_pairs = 0, dq5_pair = 0, rd_cyc = 0, we_len = 0;
  bit we_low = 1'b0, busy_p = 1'b0, oe_p = 1'b1, err_p = 1'b0;
  int to_poll = 0, to_rd_cyc = 0, to_done_cnt = 0, to_err_cnt = 0;
  bit to_err_p = 1'b0;

  always #5 m2 = ~m2;

  flash_cmd_sequencer dut (
    .m2(m2), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .error(error), .flash_addr(flash_addr),
    .flash_dq_out(flash_dq_out), .flash_dq_oe(flash_dq_oe), .flash_dq_in(flash_dq_in),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  flash_cmd_sequencer #(.WE_PULSE(2), .TIMEOUT(16'd4)) dut_to (
    .m2(m2), .rst_n(rst_n), .req(t_req), .op(2'b01), .addr(27'h0001000), .wdata(8'h00),
    .busy(t_busy), .done(t_done), .error(t_error), .flash_addr(t_faddr),
    .flash_dq_out(t_dq_out), .flash_dq_oe(t_dq_oe), .flash_dq_in(t_dq_in),
    .flash_ce_n(t_ce_n), .flash_oe_n(t_oe_n), .flash_we_n(t_we_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [1:0] o, input logic [26:0] a, input logic [7:0] d);
    case (o)
      2'b00: begin
        exp_q.push_back('{27'hAAA, 8'hAA}); exp_q.push_back('{27'h555, 8'h55});
        exp_q.push_back('{27'hAAA, 8'hA0}); exp_q.push_back('{a, d});
      end
      2'b01, 2'b10: begin
        exp_q.push_back('{27'hAAA, 8'hAA}); exp_q.push_back('{27'h555, 8'h55});
        exp_q.push_back('{27'hAAA, 8'h80}); exp_q.push_back('{27'hAAA, 8'hAA});
        exp_q.push_back('{27'h555, 8'h55});
        if (o == 2'b01) exp_q.push_back('{a, 8'h30});
        else exp_q.push_back('{27'hAAA, 8'h10});
      end
      default: exp_q.push_back('{a, 8'hF0});
    endcase
  endtask

  // Monitor and flash model for the main DUT, evaluated mid-cycle.
  always @(negedge m2) begin : mon
    int r;
    int p;
    wr_t e;
    cyc++;
    if (!rst_n) begin
      we_low = 1'b0; busy_p = 1'b0; oe_p = 1'b1; err_p = 1'b0;
      rd_cyc = 0; flash_dq_in = 8'd0;
    end else begin
      if (busy && !busy_p) t_busy_at = cyc;
      if (!flash_oe_n && oe_p && t_rd_at == 0) t_rd_at = cyc;
      if (!flash_oe_n) begin
        poll_cyc++;
        check("rd_we_n", flash_we_n, 1);
        check("rd_dq_oe", flash_dq_oe, 0);
      end
      if (!flash_we_n) begin
        if (!we_low) begin
          wr_seen++;
          we_low = 1'b1;
          we_len = 0;
          check("wr_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", flash_addr, e.a);
            check("wr_data", flash_dq_out, e.d);
          end
          check("wr_ce_n", flash_ce_n, 0);
          check("wr_oe_n", flash_oe_n, 1);
          check("wr_dq_oe", flash_dq_oe, 1);
        end
        we_len++;
      end else if (we_low) begin
        check("we_width", we_len, 2);
        we_low = 1'b0;
      end
      if (done) begin
        done_cnt++;
        t_done_at = cyc;
        check("done_vs_error", error, 0);
        check("done_busy", busy, 0);
      end
      if (error && !err_p) begin
        err_cnt++;
        t_err_at = cyc;
      end
      busy_p = busy; oe_p = flash_oe_n; err_p = error;
      // Each read spans two cycles; DQ6 flips per read while the "operation" runs.
      if (!flash_oe_n) begin
        r = rd_cyc / 2;
        p = r / 2 + 1;
        flash_dq_in = 8'd0;
        flash_dq_in[6] = (p <= toggle_pairs) ? r[0] : 1'b0;
        flash_dq_in[5] = (dq5_pair != 0 && p >= dq5_pair);
        rd_cyc++;
      end else begin
        rd_cyc = 0;
        flash_dq_in = 8'd0;
      end
    end
  end

  // Flash model for the short-timeout DUT: DQ6 toggles forever, DQ5 stays low.
  always @(negedge m2) begin : mon_to
    int r;
    if (!rst_n) begin
      to_rd_cyc = 0; t_dq_in = 8'd0; to_err_p = 1'b0;
    end else begin
      if (t_done) to_done_cnt++;
      if (t_error && !to_err_p) to_err_cnt++;
      to_err_p = t_error;
      if (!t_oe_n) begin
        to_poll++;
        r = to_rd_cyc / 2;
        t_dq_in = 8'd0;
        t_dq_in[6] = r[0];
        to_rd_cyc++;
      end else begin
        to_rd_cyc = 0;
        t_dq_in = 8'd0;
      end
    end
  end

  task automatic idle_bus(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ce_n"}, flash_ce_n, 1);
    check({tag, "_oe_n"}, flash_oe_n, 1);
    check({tag, "_we_n"}, flash_we_n, 1);
    check({tag, "_dq_oe"}, flash_dq_oe, 0);
    check({tag, "_addr"}, flash_addr, 0);
    check({tag, "_dq_out"}, flash_dq_out, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [26:0] a, input logic [7:0] d,
                        input int tog, input int f5, input logic exp_err, input int exp_lat,
                        input int exp_poll, input int exp_rd, input bit poke, input bit no_wait);
    push_seq(o, a, d);
    toggle_pairs = tog; dq5_pair = f5;
    done_cnt = 0; err_cnt = 0; poll_cyc = 0; wr_seen = 0;
    t_busy_at = 0; t_done_at = 0; t_err_at = 0; t_rd_at = 0;
    if (!no_wait) @(negedge m2);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(negedge m2);
    req = 1'b0; op = ~o; addr = ~a; wdata = ~d;
    #1;
    check("busy_rise", busy, 1);
    check("error_cleared", error, 0);
    if (poke) begin
      repeat (3) @(negedge m2);
      req = 1'b1; op = 2'b11;
      @(negedge m2);
      req = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != 0 || err_cnt != 0) break;
      @(posedge m2);
    end
    check("finish_in_budget", (done_cnt != 0 || err_cnt != 0), 1);
    repeat (3) @(posedge m2);
    #1;
    check("done_count", done_cnt, exp_err ? 0 : 1);
    check("error_count", err_cnt, exp_err ? 1 : 0);
    check("error_flag", error, exp_err);
    check("latency", (exp_err ? t_err_at : t_done_at) - t_busy_at, exp_lat);
    check("poll_cycles", poll_cyc, exp_poll);
    if (exp_rd >= 0) check("first_rd", t_rd_at - t_busy_at, exp_rd);
    check("writes_left", exp_q.size(), 0);
    idle_bus("end");
  endtask

  initial begin
    repeat (3) @(negedge m2);
    #1;
    idle_bus("reset");
    check("reset_error", error, 0);
    @(negedge m2);
    rst_n = 1'b1;

    // program, stable DQ6, with a req poked while busy
    run_op(2'b00, 27'h1234567, 8'h5A, 0, 0, 1'b0, 20, 4, 16, 1'b1, 1'b0);
    // sector erase, 10 toggling pairs
    run_op(2'b01, 27'h0020000, 8'h00, 10, 0, 1'b0, 68, 44, 24, 1'b0, 1'b0);
    // chip erase failing on the 3rd pair
    run_op(2'b10, 27'h0000000, 8'h00, 1000, 3, 1'b1, 36, 12, 24, 1'b0, 1'b0);
    // read-array reset, clears sticky error
    run_op(2'b11, 27'h0000000, 8'h00, 0, 0, 1'b0, 4, 0, -1, 1'b0, 1'b0);
    // program to the top address with two toggling pairs
    run_op(2'b00, 27'h7FFFFFF, 8'hA5, 2, 0, 1'b0, 28, 12, 16, 1'b0, 1'b0);

    // reset during WE of the second write
    push_seq(2'b00, 27'h0000040, 8'h3C);
    wr_seen = 0;
    @(negedge m2);
    req = 1'b1; op = 2'b00; addr = 27'h0000040; wdata = 8'h3C;
    @(negedge m2);
    req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_seen >= 2) break;
      @(posedge m2);
    end
    check("second_write_seen", wr_seen >= 2, 1);
    #1;
    check("we_low_before_rst", flash_we_n, 0);
    #1;
    rst_n = 1'b0;
    #1;
    idle_bus("midrst");
    exp_q.delete();
    repeat (2) @(negedge m2);
    rst_n = 1'b1;
    run_op(2'b11, 27'h0000123, 8'h00, 0, 0, 1'b0, 4, 0, -1, 1'b0, 1'b1);

    // timeout instance: always toggling, DQ5 low
    to_poll = 0;
    @(negedge m2);
    t_req = 1'b1;
    @(negedge m2);
    t_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (to_err_cnt != 0 || to_done_cnt != 0) break;
      @(posedge m2);
    end
    repeat (2) @(posedge m2);
    #1;
    check("to_error_count", to_err_cnt, 1);
    check("to_done_count", to_done_cnt, 0);
    check("to_poll_cycles", to_poll, 16);
    check("to_error_flag", t_error, 1);
    check("to_busy", t_busy, 0);
    check("to_ce_n", t_ce_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
